// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and index types for the issue/retire datapath.
package cpu_pkg;

  localparam int REG_BITS     = 5;
  localparam int XLEN         = 32;
  localparam int ROB_ENTRIES  = 8;
  localparam int ROB_TAG_BITS = $clog2(ROB_ENTRIES);

  typedef logic [ROB_TAG_BITS-1:0] rob_tag_t;
  typedef logic [REG_BITS-1:0]     reg_idx_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, completion, flush and register-file write bundle of the reorder buffer.
interface reorder_buffer_if
  import cpu_pkg::*;
#(
  parameter int ENTRIES  = ROB_ENTRIES,
  parameter int N        = REG_BITS,
  parameter int WIDTH    = XLEN,
  parameter int TAG_BITS = $clog2(ENTRIES)
) ();

  logic                alloc_valid;
  logic [N-1:0]        alloc_rd;
  logic                alloc_ready;
  logic [TAG_BITS-1:0] alloc_tag;
  logic                cmpl_valid;
  logic [TAG_BITS-1:0] cmpl_tag;
  logic [WIDTH-1:0]    cmpl_data;
  logic                flush;
  logic                wenable;
  logic [N-1:0]        reg_in;
  logic [WIDTH-1:0]    din;
  logic [TAG_BITS:0]   count;

  modport master (
    output alloc_valid, alloc_rd, cmpl_valid, cmpl_tag, cmpl_data, flush,
    input  alloc_ready, alloc_tag, wenable, reg_in, din, count
  );

  modport slave (
    input  alloc_valid, alloc_rd, cmpl_valid, cmpl_tag, cmpl_data, flush,
    output alloc_ready, alloc_tag, wenable, reg_in, din, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates per destination, completes out of order by tag,
// retires one entry per cycle into the register file write port.
module reorder_buffer
  import cpu_pkg::*;
#(
  parameter int ENTRIES  = ROB_ENTRIES,
  parameter int N        = REG_BITS,
  parameter int WIDTH    = XLEN,
  parameter int TAG_BITS = $clog2(ENTRIES)
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);

  localparam logic [TAG_BITS:0] PTR_ONE = {{TAG_BITS{1'b0}}, 1'b1};

  logic [TAG_BITS:0]   head_r;
  logic [TAG_BITS:0]   tail_r;
  logic [ENTRIES-1:0]  valid_r;
  logic [ENTRIES-1:0]  done_r;
  logic [N-1:0]        rd_r   [ENTRIES];
  logic [WIDTH-1:0]    data_r [ENTRIES];
  logic                wenable_r;
  logic [N-1:0]        reg_in_r;
  logic [WIDTH-1:0]    din_r;

  logic [TAG_BITS-1:0] head_idx_s;
  logic [TAG_BITS-1:0] tail_idx_s;
  logic                full_s;
  logic                alloc_fire_s;
  logic                cmpl_fire_s;
  logic                commit_s;

  // Decode occupancy and the three per-cycle events from current state only
  always_comb begin
    head_idx_s   = head_r[TAG_BITS-1:0];
    tail_idx_s   = tail_r[TAG_BITS-1:0];
    full_s       = (head_idx_s == tail_idx_s) && (head_r[TAG_BITS] != tail_r[TAG_BITS]);
    alloc_fire_s = bus.alloc_valid && !full_s;
    cmpl_fire_s  = bus.cmpl_valid && valid_r[bus.cmpl_tag];
    commit_s     = valid_r[head_idx_s] && done_r[head_idx_s];
  end

  // Head/tail pointers with wrap bit; flush rewinds both to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= {(TAG_BITS+1){1'b0}};
      tail_r <= {(TAG_BITS+1){1'b0}};
    end else if (bus.flush) begin
      head_r <= {(TAG_BITS+1){1'b0}};
      tail_r <= {(TAG_BITS+1){1'b0}};
    end else begin
      if (alloc_fire_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (commit_s) begin
        head_r <= head_r + PTR_ONE;
      end
    end
  end

  // Entry valid/done flags; a retiring entry's clear overrides a late re-completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {ENTRIES{1'b0}};
      done_r  <= {ENTRIES{1'b0}};
    end else if (bus.flush) begin
      valid_r <= {ENTRIES{1'b0}};
      done_r  <= {ENTRIES{1'b0}};
    end else begin
      if (cmpl_fire_s) begin
        done_r[bus.cmpl_tag] <= 1'b1;
      end
      if (alloc_fire_s) begin
        valid_r[tail_idx_s] <= 1'b1;
        done_r[tail_idx_s]  <= 1'b0;
      end
      if (commit_s) begin
        valid_r[head_idx_s] <= 1'b0;
        done_r[head_idx_s]  <= 1'b0;
      end
    end
  end

  // Entry payload; contents are qualified by valid/done so no reset is needed
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      if (alloc_fire_s) begin
        rd_r[tail_idx_s] <= bus.alloc_rd;
      end
      if (cmpl_fire_s) begin
        data_r[bus.cmpl_tag] <= bus.cmpl_data;
      end
    end
  end

  // Registered register-file write port; x0 retires without a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wenable_r <= 1'b0;
      reg_in_r  <= {N{1'b0}};
      din_r     <= {WIDTH{1'b0}};
    end else if (bus.flush) begin
      wenable_r <= 1'b0;
    end else if (commit_s) begin
      wenable_r <= (rd_r[head_idx_s] != {N{1'b0}});
      reg_in_r  <= rd_r[head_idx_s];
      din_r     <= data_r[head_idx_s];
    end else begin
      wenable_r <= 1'b0;
    end
  end

  assign bus.alloc_ready = !full_s;
  assign bus.alloc_tag   = tail_idx_s;
  assign bus.count       = tail_r - head_r;
  assign bus.wenable     = wenable_r;
  assign bus.reg_in      = reg_in_r;
  assign bus.din         = din_r;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, corner sequences and a
// randomized run against an in-order queue model.
module tb_reorder_buffer;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: queue of in-flight instructions ----------
  typedef struct {
    reg_idx_t    rd;
    logic [31:0] data;
    bit          done;
    rob_tag_t    tag;
  } inst_t;

  inst_t       mq[$];
  int          m_next_tag;
  bit          m_wen;
  reg_idx_t    m_reg;
  logic [31:0] m_din;
  bit          log_en;
  reg_idx_t    wr_log[$];

  task automatic model_reset();
    mq.delete();
    m_next_tag = 0;
    m_wen      = 1'b0;
    m_reg      = '0;
    m_din      = 32'd0;
  endtask

  task automatic model_edge(input bit av, input reg_idx_t rd, input bit cv,
                            input rob_tag_t tg, input logic [31:0] d, input bit fl);
    bit          do_commit;
    bit          can_alloc;
    inst_t       front;
    inst_t       ni;
    if (fl) begin
      mq.delete();
      m_next_tag = 0;
      m_wen      = 1'b0;
      return;
    end
    do_commit = (mq.size() > 0) && mq[0].done;
    can_alloc = (mq.size() < ROB_ENTRIES);
    if (do_commit) front = mq[0];
    if (cv) begin
      foreach (mq[i]) if (mq[i].tag == tg) begin
        mq[i].done = 1'b1;
        mq[i].data = d;
      end
    end
    if (do_commit) void'(mq.pop_front());
    if (av && can_alloc) begin
      ni.rd = rd; ni.data = 32'd0; ni.done = 1'b0; ni.tag = rob_tag_t'(m_next_tag);
      mq.push_back(ni);
      m_next_tag = (m_next_tag + 1) % ROB_ENTRIES;
    end
    m_wen = do_commit && (front.rd != 5'd0);
    if (do_commit) begin
      m_reg = front.rd;
      m_din = front.data;
    end
  endtask

  // ---------------- checking helpers ------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string ctx);
    chk({ctx, ".wenable"},     32'(bus.wenable),     32'(m_wen));
    chk({ctx, ".reg_in"},      32'(bus.reg_in),      32'(m_reg));
    chk({ctx, ".din"},         bus.din,              m_din);
    chk({ctx, ".count"},       32'(bus.count),       32'(mq.size()));
    chk({ctx, ".alloc_ready"}, 32'(bus.alloc_ready), 32'(mq.size() < ROB_ENTRIES));
    chk({ctx, ".alloc_tag"},   32'(bus.alloc_tag),   32'(m_next_tag));
  endtask

  // Drive one cycle (called at posedge+1), advance the model, sample at next posedge+1
  task automatic drive(input bit av, input reg_idx_t rd, input bit cv,
                       input rob_tag_t tg, input logic [31:0] d, input bit fl);
    bus.alloc_valid = av;
    bus.alloc_rd    = rd;
    bus.cmpl_valid  = cv;
    bus.cmpl_tag    = tg;
    bus.cmpl_data   = d;
    bus.flush       = fl;
    model_edge(av, rd, cv, tg, d, fl);
    @(posedge clk);
    #1;
    if (log_en && bus.wenable) wr_log.push_back(bus.reg_in);
  endtask

  task automatic step(input string ctx, input bit av, input reg_idx_t rd, input bit cv,
                      input rob_tag_t tg, input logic [31:0] d, input bit fl);
    drive(av, rd, cv, tg, d, fl);
    check_model(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.alloc_valid = 1'b0; bus.alloc_rd = 5'd0; bus.cmpl_valid = 1'b0;
    bus.cmpl_tag = 3'd0; bus.cmpl_data = 32'd0; bus.flush = 1'b0;
    model_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- directed table ---------------------------------------------
  typedef struct {
    bit          av;
    reg_idx_t    rd;
    bit          cv;
    rob_tag_t    tg;
    logic [31:0] d;
    bit          wen;
    reg_idx_t    rg;
    logic [31:0] dout;
    int          cnt;
    int          tag;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    log_en   = 1'b0;

    tbl[0] = '{1'b1, 5'd3, 1'b0, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1, 1};
    tbl[1] = '{1'b1, 5'd4, 1'b0, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2, 2};
    tbl[2] = '{1'b1, 5'd5, 1'b0, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3, 3};
    tbl[3] = '{1'b0, 5'd0, 1'b1, 3'd2, 32'hC, 1'b0, 5'd0, 32'h0, 3, 3};
    tbl[4] = '{1'b0, 5'd0, 1'b1, 3'd0, 32'hA, 1'b0, 5'd0, 32'h0, 3, 3};
    tbl[5] = '{1'b0, 5'd0, 1'b1, 3'd1, 32'hB, 1'b1, 5'd3, 32'hA, 2, 3};
    tbl[6] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1, 5'd4, 32'hB, 1, 3};
    tbl[7] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1, 5'd5, 32'hC, 0, 3};
    tbl[8] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 5'd5, 32'hC, 0, 3};

    // reset state
    do_reset();
    chk("reset.wenable",     32'(bus.wenable),     32'd0);
    chk("reset.count",       32'(bus.count),       32'd0);
    chk("reset.alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("reset.alloc_tag",   32'(bus.alloc_tag),   32'd0);
    chk("reset.din",         bus.din,              32'd0);

    // in-order retirement of out-of-order completions
    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].rd, tbl[i].cv, tbl[i].tg, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d.wenable", i),   32'(bus.wenable),   32'(tbl[i].wen));
      chk($sformatf("tbl%0d.reg_in", i),    32'(bus.reg_in),    32'(tbl[i].rg));
      chk($sformatf("tbl%0d.din", i),       bus.din,            tbl[i].dout);
      chk($sformatf("tbl%0d.count", i),     32'(bus.count),     32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.alloc_tag", i), 32'(bus.alloc_tag), 32'(tbl[i].tag));
    end

    // full: 8 allocations, 9th ignored, alloc blocked on the commit cycle
    do_reset();
    for (int i = 0; i < 8; i++) step("full.alloc", 1'b1, reg_idx_t'(i + 1), 1'b0, 3'd0, 32'd0, 1'b0);
    chk("full.count8", 32'(bus.count), 32'd8);
    chk("full.ready0", 32'(bus.alloc_ready), 32'd0);
    step("full.ninth", 1'b1, 5'd20, 1'b0, 3'd0, 32'd0, 1'b0);
    chk("full.ninth_count", 32'(bus.count), 32'd8);
    step("full.cmpl0", 1'b0, 5'd0, 1'b1, 3'd0, 32'h55, 1'b0);
    step("full.commit", 1'b1, 5'd21, 1'b0, 3'd0, 32'd0, 1'b0);
    chk("full.commit_wen", 32'(bus.wenable), 32'd1);
    chk("full.commit_din", bus.din, 32'h55);
    chk("full.after_count", 32'(bus.count), 32'd7);
    chk("full.after_ready", 32'(bus.alloc_ready), 32'd1);

    // wrap: 12 alloc/complete pairs, writes must come out rd=1..12
    do_reset();
    log_en = 1'b1;
    wr_log.delete();
    for (int i = 1; i <= 12; i++) begin
      chk("wrap.tag", 32'(bus.alloc_tag), 32'((i - 1) % 8));
      step("wrap.alloc", 1'b1, reg_idx_t'(i), 1'b0, 3'd0, 32'd0, 1'b0);
      step("wrap.cmpl", 1'b0, 5'd0, 1'b1, rob_tag_t'((i - 1) % 8), 32'(i * 16), 1'b0);
    end
    for (int i = 0; i < 3; i++) idle("wrap.drain");
    log_en = 1'b0;
    chk("wrap.nwrites", 32'(wr_log.size()), 32'd12);
    foreach (wr_log[k]) chk($sformatf("wrap.order%0d", k), 32'(wr_log[k]), 32'(k + 1));

    // x0 retire and stray completion
    do_reset();
    step("x0.alloc", 1'b1, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    step("x0.cmpl", 1'b0, 5'd0, 1'b1, 3'd0, 32'h77, 1'b0);
    idle("x0.retire");
    chk("x0.wenable", 32'(bus.wenable), 32'd0);
    chk("x0.count", 32'(bus.count), 32'd0);
    chk("x0.alloc_tag", 32'(bus.alloc_tag), 32'd1);
    step("stray.alloc1", 1'b1, 5'd7, 1'b0, 3'd0, 32'd0, 1'b0);
    step("stray.cmpl2", 1'b0, 5'd0, 1'b1, 3'd2, 32'hDEAD, 1'b0);
    step("stray.alloc2", 1'b1, 5'd8, 1'b0, 3'd0, 32'd0, 1'b0);
    step("stray.cmpl1", 1'b0, 5'd0, 1'b1, 3'd1, 32'h11, 1'b0);
    idle("stray.commit1");
    idle("stray.hold");
    chk("stray.wenable", 32'(bus.wenable), 32'd0);
    chk("stray.count", 32'(bus.count), 32'd1);

    // flush with same-cycle alloc/completion dropped
    do_reset();
    for (int i = 0; i < 4; i++) step("flush.alloc", 1'b1, reg_idx_t'(i + 10), 1'b0, 3'd0, 32'd0, 1'b0);
    step("flush.cmpl1", 1'b0, 5'd0, 1'b1, 3'd1, 32'h1, 1'b0);
    step("flush.cmpl2", 1'b0, 5'd0, 1'b1, 3'd2, 32'h2, 1'b0);
    step("flush.go", 1'b1, 5'd9, 1'b1, 3'd0, 32'h3, 1'b1);
    chk("flush.count", 32'(bus.count), 32'd0);
    chk("flush.alloc_tag", 32'(bus.alloc_tag), 32'd0);
    for (int i = 0; i < 3; i++) idle("flush.quiet");
    chk("flush.wenable", 32'(bus.wenable), 32'd0);

    // asynchronous reset mid-cycle while a commit is pending
    do_reset();
    step("ar.alloc0", 1'b1, 5'd9, 1'b0, 3'd0, 32'd0, 1'b0);
    step("ar.alloc1", 1'b1, 5'd10, 1'b0, 3'd0, 32'd0, 1'b0);
    step("ar.cmpl0", 1'b0, 5'd0, 1'b1, 3'd0, 32'h90, 1'b0);
    step("ar.cmpl1", 1'b0, 5'd0, 1'b1, 3'd1, 32'hA0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("ar.wenable", 32'(bus.wenable), 32'd0);
    chk("ar.count", 32'(bus.count), 32'd0);
    chk("ar.alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("ar.alloc_tag", 32'(bus.alloc_tag), 32'd0);
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    idle("ar.after");

    // randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit       av;
      bit       cv;
      bit       fl;
      rob_tag_t tg;
      av = ($urandom_range(0, 9) < 6);
      cv = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 99) < 2);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        tg = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        tg = rob_tag_t'($urandom_range(0, 7));
      step("rand", av, reg_idx_t'($urandom_range(0, 31)), cv, tg, $urandom, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
